// File: rtl/row_result_pack_pkg.sv
// row_result_pack_pkg: shared compute-engine sizes and row-bank state encoding.
package row_result_pack_pkg;
    localparam int DEF_OUTQ_BITS = 32;
    localparam int DEF_PE_NUM = 8;
    typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_t;
endpackage

// File: rtl/row_result_pack_row_bank.sv
// row_bank: one row of lane storage with its fill state and valid-lane count.
module row_bank
    import row_result_pack_pkg::*;
#(
    parameter int OUTQ_BITS = DEF_OUTQ_BITS,
    parameter int PE_NUM = DEF_PE_NUM
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          wr_en,
    input  logic [$clog2(PE_NUM)-1:0]     wr_lane,
    input  logic [OUTQ_BITS-1:0]          wr_result,
    input  logic [OUTQ_BITS-1:0]          wr_actsum,
    input  logic                          close,
    input  logic [3:0]                    close_count,
    output logic                          full,
    output logic [3:0]                    count,
    output logic [PE_NUM*OUTQ_BITS-1:0]   result,
    output logic [PE_NUM*OUTQ_BITS-1:0]   actsum
);
    bank_state_t state, state_next;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= BANK_EMPTY;
        else state <= state_next;
    always_comb state_next = close ? BANK_FULL : wr_en ? BANK_FILLING : clear ? BANK_EMPTY : state;
    always_comb full = state == BANK_FULL;
    // a clear and a write in the same edge: the clear lands first, the word survives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
            actsum <= '0;
            count <= '0;
        end else begin
            if (clear) begin
                result <= '0;
                actsum <= '0;
                count <= '0;
            end
            if (wr_en) begin
                result[wr_lane*OUTQ_BITS +: OUTQ_BITS] <= wr_result;
                actsum[wr_lane*OUTQ_BITS +: OUTQ_BITS] <= wr_actsum;
            end
            if (close) count <= close_count;
        end
    end
endmodule

// File: rtl/row_result_pack.sv
// row_result_pack: packs serial result/actsum words into ping-pong rows of PE_NUM lanes.
module row_result_pack
    import row_result_pack_pkg::*;
#(
    parameter int OUTQ_BITS = DEF_OUTQ_BITS,
    parameter int PE_NUM = DEF_PE_NUM
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in,
    input  logic [OUTQ_BITS-1:0]          serial_result,
    input  logic [OUTQ_BITS-1:0]          serial_actresult,
    input  logic                          flush,
    output logic                          row_valid,
    input  logic                          row_ready,
    output logic [PE_NUM*OUTQ_BITS-1:0]   row_result,
    output logic [PE_NUM*OUTQ_BITS-1:0]   row_actsum,
    output logic [3:0]                    row_count,
    output logic                          overflow
);
    localparam int IW = $clog2(PE_NUM);
    logic wb, rb, xfer, wb_full, accept, close_row;
    logic [IW-1:0] wr_idx;
    logic [3:0] close_cnt;
    logic [1:0] full;
    logic [3:0] cnt [2];
    logic [PE_NUM*OUTQ_BITS-1:0] res [2];
    logic [PE_NUM*OUTQ_BITS-1:0] act [2];
    for (genvar b = 0; b < 2; b++) begin : g_bank
        row_bank #(.OUTQ_BITS(OUTQ_BITS), .PE_NUM(PE_NUM)) u_bank (
            .clk(clk),
            .reset(reset),
            .clear(xfer && rb == 1'(b)),
            .wr_en(accept && wb == 1'(b)),
            .wr_lane(wr_idx),
            .wr_result(serial_result),
            .wr_actsum(serial_actresult),
            .close(close_row && wb == 1'(b)),
            .close_count(close_cnt),
            .full(full[b]),
            .count(cnt[b]),
            .result(res[b]),
            .actsum(act[b])
        );
    end
    // the write bank counts as free if it is being handed off this very cycle
    always_comb begin
        row_valid = full[rb];
        xfer = row_valid && row_ready;
        wb_full = full[wb] && !(xfer && rb == wb);
        accept = valid_in && !wb_full;
        close_row = (accept && wr_idx == IW'(PE_NUM - 1)) || (flush && (accept || wr_idx != '0));
        close_cnt = 4'(wr_idx) + (accept ? 4'd1 : 4'd0);
        row_result = row_valid ? res[rb] : '0;
        row_actsum = row_valid ? act[rb] : '0;
        row_count = row_valid ? cnt[rb] : 4'd0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb <= 1'b0;
            rb <= 1'b0;
            wr_idx <= '0;
            overflow <= 1'b0;
        end else begin
            if (xfer) rb <= ~rb;
            if (valid_in && wb_full) overflow <= 1'b1;
            if (close_row) begin
                wb <= ~wb;
                wr_idx <= '0;
            end else if (accept) wr_idx <= wr_idx + IW'(1);
        end
    end
endmodule

// File: tb/tb_row_result_pack.sv
// tb_row_result_pack: table vectors, corner sequences and random traffic against a row-queue model.
module tb_row_result_pack;
    localparam int W = 32;
    localparam int N = 8;
    localparam int B = W * N;
    logic clk = 1'b0, reset = 1'b0, valid_in = 1'b0, flush = 1'b0, row_ready = 1'b0;
    logic [W-1:0] serial_result = '0, serial_actresult = '0;
    logic row_valid, overflow;
    logic [B-1:0] row_result, row_actsum;
    logic [3:0] row_count;
    int checks = 0, failures = 0;

    row_result_pack #(.OUTQ_BITS(W), .PE_NUM(N)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .serial_result(serial_result),
        .serial_actresult(serial_actresult), .flush(flush), .row_valid(row_valid),
        .row_ready(row_ready), .row_result(row_result), .row_actsum(row_actsum),
        .row_count(row_count), .overflow(overflow)
    );
    always #5 clk = ~clk;

    // model: completed rows waiting in order, plus the row being gathered
    typedef struct { logic [B-1:0] res; logic [B-1:0] act; int cnt; } row_t;
    row_t q[$];
    logic [B-1:0] pres, pact;
    int plen;
    logic movf;

    typedef struct { logic v; logic [W-1:0] d; logic f; logic r; logic ev; logic [3:0] ec; logic [W-1:0] e0; logic eo; } vec_t;
    vec_t tbl[21];

    function automatic vec_t mk(int v, int d, int f, int r, int ev, int ec, int e0, int eo);
        mk.v = v[0]; mk.d = d; mk.f = f[0]; mk.r = r[0];
        mk.ev = ev[0]; mk.ec = ec[3:0]; mk.e0 = e0; mk.eo = eo[0];
    endfunction

    task automatic chk(input string name, input logic [B-1:0] act_v, input logic [B-1:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act_v, exp_v);
        end
    endtask

    task automatic close_partial();
        q.push_back('{pres, pact, plen});
        pres = '0; pact = '0; plen = 0;
    endtask

    task automatic model_edge(input logic v, input logic [W-1:0] d, input logic [W-1:0] a, input logic f, input logic r);
        if (q.size() > 0 && r) void'(q.pop_front());
        if (v) begin
            if (q.size() == 2) movf = 1'b1;
            else begin
                pres[plen*W +: W] = d;
                pact[plen*W +: W] = a;
                plen++;
                if (plen == N || f) close_partial();
            end
        end else if (f && plen > 0) close_partial();
    endtask

    task automatic check_outputs();
        logic ev;
        ev = q.size() > 0;
        chk("row_valid", B'(row_valid), B'(ev));
        chk("row_count", B'(row_count), ev ? B'(q[0].cnt) : '0);
        chk("row_result", row_result, ev ? q[0].res : '0);
        chk("row_actsum", row_actsum, ev ? q[0].act : '0);
        chk("overflow", B'(overflow), B'(movf));
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic [W-1:0] a, input logic f, input logic r);
        valid_in = v; serial_result = d; serial_actresult = a; flush = f; row_ready = r;
        model_edge(v, d, a, f, r);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        valid_in = 1'b0; flush = 1'b0; row_ready = 1'b0;
        reset = 1'b1;
        q.delete(); pres = '0; pact = '0; plen = 0; movf = 1'b0;
        #2;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = mk(1, 'hA, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(1, 'hB, 0, 0, 0, 0, 0, 0);
        tbl[2] = mk(1, 'hC, 0, 0, 0, 0, 0, 0);
        tbl[3] = mk(0, 0, 1, 0, 1, 3, 'hA, 0);
        tbl[4] = mk(0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) tbl[5+k] = mk(1, k + 1, 0, 0, 0, 0, 0, 0);
        tbl[9] = mk(1, 5, 1, 0, 1, 5, 1, 0);
        tbl[10] = mk(0, 0, 0, 1, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) tbl[12+k] = mk(1, 'h11 + k, 0, 1, 0, 0, 0, 0);
        tbl[19] = mk(1, 'h18, 0, 1, 1, 8, 'h11, 0);
        tbl[20] = mk(0, 0, 0, 1, 0, 0, 0, 0);
        #1;
        do_reset();
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].d + 'h10, tbl[i].f, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), B'(row_valid), B'(tbl[i].ev));
            chk($sformatf("tbl%0d_count", i), B'(row_count), B'(tbl[i].ec));
            chk($sformatf("tbl%0d_lane0", i), B'(row_result[W-1:0]), B'(tbl[i].e0));
            chk($sformatf("tbl%0d_ovf", i), B'(overflow), B'(tbl[i].eo));
        end
        do_reset();
        for (int i = 1; i <= 17; i++) step(1'b1, W'(i), W'(i + 'h10), 1'b0, 1'b0);
        chk("drop_ovf", B'(overflow), B'(1));
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("hold_lane0", B'(row_result[W-1:0]), B'(1));
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("b2b_valid", B'(row_valid), B'(1));
        chk("b2b_lane0", B'(row_result[W-1:0]), B'(9));
        chk("b2b_lane7", B'(row_result[7*W +: W]), B'(16));
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("ovf_sticky", B'(overflow), B'(1));
        do_reset();
        for (int i = 1; i <= 16; i++) step(1'b1, W'(i), W'(i), 1'b0, 1'b0);
        step(1'b1, W'('h99), W'('h99), 1'b0, 1'b1);
        chk("freed_ovf", B'(overflow), B'(0));
        chk("freed_lane0", B'(row_result[W-1:0]), B'(9));
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("freed_count", B'(row_count), B'(1));
        chk("freed_word", B'(row_result[W-1:0]), B'('h99));
        do_reset();
        for (int i = 1; i <= 12; i++) step(1'b1, W'(i), W'(i), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, W'('h51 + i), W'('h61 + i), 1'b0, 1'b0);
        chk("fresh_count", B'(row_count), B'(8));
        chk("fresh_lane0", B'(row_result[W-1:0]), B'('h51));
        do_reset();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
